// File: rtl/dca_matrix_lsu_arbiter_if.sv
// Requester-side and memory-side handshake bundle for the LSU arbiter.
// slave = arbiter view, master = requesters/memory environment view.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

interface dca_matrix_lsu_arbiter_if #(
  parameter int BW_LSU_INST = `BW_DCA_MATRIX_LSU_INST
);
  logic                   r0_valid, r1_valid, r2_valid;
  logic [BW_LSU_INST-1:0] r0_inst,  r1_inst,  r2_inst;
  logic                   r0_ready, r1_ready, r2_ready;
  logic                   r0_done,  r1_done,  r2_done;
  logic                   m_valid;
  logic [BW_LSU_INST-1:0] m_inst;
  logic [1:0]             m_src;
  logic                   m_ready;
  logic                   m_done;

  modport slave (
    input  r0_valid, r1_valid, r2_valid, r0_inst, r1_inst, r2_inst,
    output r0_ready, r1_ready, r2_ready, r0_done, r1_done, r2_done,
    output m_valid, m_inst, m_src,
    input  m_ready, m_done
  );

  modport master (
    output r0_valid, r1_valid, r2_valid, r0_inst, r1_inst, r2_inst,
    input  r0_ready, r1_ready, r2_ready, r0_done, r1_done, r2_done,
    input  m_valid, m_inst, m_src,
    output m_ready, m_done
  );
endinterface

// File: rtl/dca_matrix_lsu_arbiter.sv
// Three-way round-robin arbiter onto one registered LSU memory port, with an
// in-order source-tag FIFO that routes completion pulses back to requesters.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

module dca_matrix_lsu_arbiter #(
  parameter int BW_LSU_INST       = `BW_DCA_MATRIX_LSU_INST,
  parameter int OUTSTANDING_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstnn,
  input  logic                     clear,
  input  logic                     enable,
  dca_matrix_lsu_arbiter_if.slave  bus,
  output logic                     busy,
  output logic                     err_spurious_done
);
  localparam int PW = $clog2(OUTSTANDING_DEPTH);
  localparam int CW = PW + 1;

  logic                   m_valid_q, m_valid_d;
  logic [BW_LSU_INST-1:0] m_inst_q,  m_inst_d;
  logic [1:0]             m_src_q,   m_src_d;
  logic [1:0]             last_q,    last_d;
  logic [CW-1:0]          outst_q,   outst_d;
  logic [PW-1:0]          wr_q,      wr_d;
  logic [PW-1:0]          rd_q,      rd_d;
  logic                   err_q,     err_d;
  logic [1:0]             tag_q [OUTSTANDING_DEPTH];

  logic [2:0]             req_vld;
  logic [1:0]             idx;
  logic [1:0]             winner;
  logic                   win_vld;
  logic [BW_LSU_INST-1:0] win_inst;
  logic                   slot_free, grant, handshake, done_acc, spurious;
  logic [1:0]             head;
  logic [2:0]             ready_vec, done_vec;

  assign req_vld   = {bus.r2_valid, bus.r1_valid, bus.r0_valid};
  assign slot_free = enable & ~clear & (~m_valid_q | bus.m_ready) &
                     (outst_q < CW'(OUTSTANDING_DEPTH));
  assign handshake = enable & m_valid_q & bus.m_ready;
  assign done_acc  = enable & ~clear & bus.m_done & (outst_q != '0);
  assign spurious  = enable & bus.m_done & (outst_q == '0);
  assign head      = tag_q[rd_q];

  // Scan requesters starting just after the previous winner.
  always_comb begin
    idx     = '0;
    winner  = '0;
    win_vld = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      idx = 2'((32'(last_q) + 1 + i) % 3);
      if (!win_vld && req_vld[idx]) begin
        win_vld = 1'b1;
        winner  = idx;
      end
    end
  end

  always_comb begin
    case (winner)
      2'd0:    win_inst = bus.r0_inst;
      2'd1:    win_inst = bus.r1_inst;
      default: win_inst = bus.r2_inst;
    endcase
  end

  assign grant     = slot_free & win_vld;
  assign ready_vec = grant    ? (3'b001 << winner) : '0;
  assign done_vec  = done_acc ? (3'b001 << head)   : '0;

  assign {bus.r2_ready, bus.r1_ready, bus.r0_ready} = ready_vec;
  assign {bus.r2_done,  bus.r1_done,  bus.r0_done}  = done_vec;
  assign bus.m_valid        = m_valid_q;
  assign bus.m_inst         = m_inst_q;
  assign bus.m_src          = m_src_q;
  assign busy               = m_valid_q | (outst_q != '0);
  assign err_spurious_done  = err_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_inst_d  = m_inst_q;
    m_src_d   = m_src_q;
    last_d    = last_q;
    outst_d   = outst_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    err_d     = err_q;
    if (clear) begin
      m_valid_d = 1'b0;
      m_inst_d  = '0;
      m_src_d   = '0;
      last_d    = 2'd2;
      outst_d   = '0;
      wr_d      = '0;
      rd_d      = '0;
      err_d     = 1'b0;
    end else begin
      if (grant) begin
        m_valid_d = 1'b1;
        m_inst_d  = win_inst;
        m_src_d   = winner;
        last_d    = winner;
        wr_d      = wr_q + PW'(1);
      end else if (handshake) begin
        m_valid_d = 1'b0;
      end
      if (done_acc) rd_d = rd_q + PW'(1);
      case ({grant, done_acc})
        2'b10:   outst_d = outst_q + CW'(1);
        2'b01:   outst_d = outst_q - CW'(1);
        default: outst_d = outst_q;
      endcase
      if (spurious) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      m_valid_q <= 1'b0;
      m_inst_q  <= '0;
      m_src_q   <= '0;
      last_q    <= 2'd2;
      outst_q   <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < OUTSTANDING_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_inst_q  <= m_inst_d;
      m_src_q   <= m_src_d;
      last_q    <= last_d;
      outst_q   <= outst_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      if (grant) tag_q[wr_q] <= winner;
    end
  end
endmodule

// File: tb/tb_dca_matrix_lsu_arbiter.sv
// Directed bench for dca_matrix_lsu_arbiter: round-robin order, stall, depth
// limit, in-order done routing, spurious done, enable gating and clear.
module tb_dca_matrix_lsu_arbiter;
  logic clk = 1'b0;
  logic rstnn = 1'b0;
  logic clear = 1'b0;
  logic enable = 1'b1;
  logic busy, err_spurious_done;
  int   checks = 0;
  int   failures = 0;

  dca_matrix_lsu_arbiter_if #(.BW_LSU_INST(32)) bus ();

  dca_matrix_lsu_arbiter #(
    .BW_LSU_INST(32),
    .OUTSTANDING_DEPTH(4)
  ) dut (
    .clk(clk),
    .rstnn(rstnn),
    .clear(clear),
    .enable(enable),
    .bus(bus),
    .busy(busy),
    .err_spurious_done(err_spurious_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdy();
    return {29'd0, bus.r2_ready, bus.r1_ready, bus.r0_ready};
  endfunction

  function automatic logic [31:0] dn();
    return {29'd0, bus.r2_done, bus.r1_done, bus.r0_done};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vld(input logic [2:0] v);
    bus.r0_valid = v[0];
    bus.r1_valid = v[1];
    bus.r2_valid = v[2];
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vld(3'b000);
    bus.r0_inst = 32'h1000_0010;
    bus.r1_inst = 32'h2000_0021;
    bus.r2_inst = 32'h3000_0032;
    bus.m_ready = 1'b0;
    bus.m_done  = 1'b0;

    // Reset state
    #12;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_inst", bus.m_inst, 0);
    check("rst_m_src", bus.m_src, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_spurious_done, 0);
    check("rst_ready", rdy(), 0);
    @(negedge clk);
    rstnn = 1'b1;
    tick();

    // Round-robin with all requesters valid; one done per cycle keeps one outstanding
    set_vld(3'b111);
    bus.m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.m_done = (k > 0);
      #1;
      check("rr_ready", rdy(), 32'd1 << (k % 3));
      if (k > 0) begin
        check("rr_src", bus.m_src, (k - 1) % 3);
        check("rr_done", dn(), 32'd1 << ((k - 1) % 3));
      end
      if (k == 1) check("rr_inst", bus.m_inst, 32'h1000_0010);
      tick();
    end
    set_vld(3'b000);
    #1;
    check("rr_last_done", dn(), 4);
    check("rr_last_ready", rdy(), 0);
    tick();
    bus.m_done = 1'b0;
    #1;
    check("rr_idle_valid", bus.m_valid, 0);
    check("rr_idle_busy", busy, 0);

    // Stall: r1 held on the port while m_ready=0
    bus.r1_inst = 32'hAAAA_0001;
    bus.m_ready = 1'b0;
    set_vld(3'b010);
    #1;
    check("stall_grant_r1", rdy(), 2);
    tick();
    set_vld(3'b001);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_valid", bus.m_valid, 1);
      check("stall_src", bus.m_src, 1);
      check("stall_inst", bus.m_inst, 32'hAAAA_0001);
      check("stall_no_grant", rdy(), 0);
      tick();
    end
    bus.m_ready = 1'b1;
    #1;
    check("stall_release_r0", rdy(), 1);
    tick();
    check("stall_next_src", bus.m_src, 0);
    check("stall_next_inst", bus.m_inst, 32'h1000_0010);
    set_vld(3'b000);
    tick();
    bus.m_done = 1'b1;
    #1;
    check("stall_done_r1", dn(), 2);
    tick();
    check("stall_done_r0", dn(), 1);
    tick();
    bus.m_done = 1'b0;
    #1;
    check("stall_busy", busy, 0);

    // Depth limit: four grants fill the tag FIFO
    set_vld(3'b001);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("depth_grant", rdy(), 1);
      tick();
    end
    #1;
    check("depth_full_stall", rdy(), 0);
    tick();
    bus.m_done = 1'b1;
    #1;
    check("depth_full_done_ready", rdy(), 0);
    check("depth_full_done_pulse", dn(), 1);
    tick();
    bus.m_done = 1'b0;
    #1;
    check("depth_after_done", rdy(), 1);
    tick();
    set_vld(3'b000);
    tick();
    bus.m_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("depth_drain", dn(), 1);
      tick();
    end
    bus.m_done = 1'b0;
    #1;
    check("depth_busy", busy, 0);

    // In-order done routing: grants r2, r0, r2
    set_vld(3'b100);
    #1; check("order_g0", rdy(), 4); tick();
    set_vld(3'b001);
    #1; check("order_g1", rdy(), 1); tick();
    set_vld(3'b100);
    #1; check("order_g2", rdy(), 4); tick();
    set_vld(3'b000);
    tick();
    bus.m_done = 1'b1;
    #1; check("order_d0", dn(), 4); tick();
    check("order_d1", dn(), 1); tick();
    check("order_d2", dn(), 4); tick();
    bus.m_done = 1'b0;
    #1;
    check("order_busy", busy, 0);

    // Spurious done with nothing outstanding
    bus.m_done = 1'b1;
    #1;
    check("spur_no_done", dn(), 0);
    check("spur_err_before", err_spurious_done, 0);
    tick();
    bus.m_done = 1'b0;
    #1;
    check("spur_err_set", err_spurious_done, 1);
    tick(); tick();
    check("spur_err_sticky", err_spurious_done, 1);

    // Enable low blocks grants and completions
    enable = 1'b0;
    set_vld(3'b001);
    bus.m_done = 1'b1;
    #1;
    check("en_no_ready", rdy(), 0);
    check("en_no_done", dn(), 0);
    tick();
    check("en_no_valid", bus.m_valid, 0);
    enable = 1'b1;
    set_vld(3'b000);
    bus.m_done = 1'b0;

    // Clear mid-operation: three outstanding, m_valid high, last grant r0
    set_vld(3'b010);
    #1; check("clr_g_r1", rdy(), 2); tick();
    set_vld(3'b100);
    #1; check("clr_g_r2", rdy(), 4); tick();
    set_vld(3'b001);
    #1; check("clr_g_r0", rdy(), 1); tick();
    check("clr_pre_valid", bus.m_valid, 1);
    set_vld(3'b111);
    clear = 1'b1;
    #1;
    check("clr_no_ready", rdy(), 0);
    tick();
    clear = 1'b0;
    #1;
    check("clr_m_valid", bus.m_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_err", err_spurious_done, 0);
    check("clr_r0_first", rdy(), 1);
    tick();
    set_vld(3'b000);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
